// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared definitions for the SPI access arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, ISSUE, RELEASE, DONE)
//   TMO_CNT_W   : width of the ISSUE-phase timeout counter
//   ERR_CNT_W   : width of the saturating timeout error counter
//   MAX_REQ     : largest supported number of requesters
//   IDX_W       : width of a requester index
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  localparam int TMO_CNT_W = 16;
  localparam int ERR_CNT_W = 8;
  localparam int MAX_REQ   = 4;
  localparam int IDX_W     = 2;

endpackage

// File: rtl/spi_access_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req         : level request vector, one bit per requester
//   last_grant  : index of the most recently granted requester
//   grant_valid : high when at least one request is pending
//   grant_idx   : first requesting index after last_grant (wrapping)
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  // Padding to the maximum width lets a full-width index select any bit
  // without width games when N_REQ is smaller than MAX_REQ.
  logic [MAX_REQ-1:0] req_pad;
  assign req_pad = MAX_REQ'(req);

  // Walk the requesters starting one past the last winner; the first
  // pending request found wins, so the last winner is checked last.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (!grant_valid && req_pad[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/spi_access_arbiter.sv
// spi_access_arbiter: shares one SPI engine between up to four requesters.
//   clk_i, reset_i         : clock, asynchronous active-high reset
//   req_i/req_dat_i/req_sel_i : per-requester level request, word, select
//   ack_o, err_o           : one-cycle completion / timeout pulses to owner
//   rsp_dat_o              : SPI_I captured when the engine signals done
//   SPI_O/SPI_SEL_O/SPI_START_O : word, select and start to the engine
//   SPI_I, SPI_DONE_I      : engine read data and done level
//   busy_o, owner_o        : not-idle flag, current/last granted index
//   err_cnt_o              : saturating count of timed-out transactions
module spi_access_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [32*N_REQ-1:0]    req_dat_i,
  input  logic [2*N_REQ-1:0]     req_sel_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [N_REQ-1:0]       err_o,
  output logic [31:0]            rsp_dat_o,
  output logic [31:0]            SPI_O,
  output logic [1:0]             SPI_SEL_O,
  output logic                   SPI_START_O,
  input  logic [31:0]            SPI_I,
  input  logic                   SPI_DONE_I,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q;
  logic                   err_flag_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [31:0]            grant_dat;
  logic [1:0]             grant_sel;
  logic                   do_grant;
  logic                   do_capture;
  logic                   do_timeout;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req         (req_i),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Select the winning requester's word and device select.
  always_comb begin
    grant_dat = '0;
    grant_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        grant_dat = req_dat_i[32*k +: 32];
        grant_sel = req_sel_i[2*k +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and one-cycle datapath strobes. A done level still high
  // from the previous transaction blocks a new grant; in ISSUE, done
  // takes precedence over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid && !SPI_DONE_I) begin
          do_grant = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (SPI_DONE_I) begin
          do_capture = 1'b1;
          state_d    = RELEASE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          do_timeout = 1'b1;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        if (!SPI_DONE_I) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered datapath. START and busy are computed from the next state
  // so they are flop outputs yet line up with the state they describe.
  // last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      SPI_START_O  <= 1'b0;
      busy_o       <= 1'b0;
      SPI_O        <= '0;
      SPI_SEL_O    <= '0;
      rsp_dat_o    <= '0;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      tmo_cnt_q    <= '0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      SPI_START_O <= (state_d == ISSUE);
      busy_o      <= (state_d != IDLE);
      if (do_grant) begin
        SPI_O        <= grant_dat;
        SPI_SEL_O    <= grant_sel;
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
        tmo_cnt_q    <= '0;
      end else if (state_q == ISSUE) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
      end
      if (do_capture) begin
        rsp_dat_o  <= SPI_I;
        err_flag_q <= 1'b0;
      end
      if (do_timeout) begin
        err_flag_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  // Completion pulses decode straight from the DONE state and owner.
  assign ack_o     = (state_q == DONE) ? (N_REQ'(1) << owner_q) : '0;
  assign err_o     = err_flag_q ? ack_o : '0;
  assign owner_o   = owner_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_spi_access_arbiter.sv
// tb_spi_access_arbiter: scoreboard bench for spi_access_arbiter with
// N_REQ=2 and TIMEOUT_CYCLES=8. A small engine model answers SPI_START_O
// after a programmable number of start cycles (0 = never answers).
module tb_spi_access_arbiter;

  localparam int NREQ = 2;
  localparam int TMO  = 8;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [NREQ-1:0]   req_i = '0;
  logic [32*NREQ-1:0] req_dat_i = '0;
  logic [2*NREQ-1:0] req_sel_i = '0;
  logic [NREQ-1:0]   ack_o;
  logic [NREQ-1:0]   err_o;
  logic [31:0]       rsp_dat_o;
  logic [31:0]       SPI_O;
  logic [1:0]        SPI_SEL_O;
  logic              SPI_START_O;
  logic [31:0]       SPI_I = '0;
  logic              SPI_DONE_I = 1'b0;
  logic              busy_o;
  logic [1:0]        owner_o;
  logic [7:0]        err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  owner;
    logic        err;
    logic [31:0] rsp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_exp;
  logic [31:0] model_rsp = '0;

  int eng_delay      = 0;
  bit eng_manual     = 1'b0;
  int start_cnt      = 0;
  int last_start_len = 0;
  int lat;

  spi_access_arbiter #(.N_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rsp_dat_o   (rsp_dat_o),
    .SPI_O       (SPI_O),
    .SPI_SEL_O   (SPI_SEL_O),
    .SPI_START_O (SPI_START_O),
    .SPI_I       (SPI_I),
    .SPI_DONE_I  (SPI_DONE_I),
    .busy_o      (busy_o),
    .owner_o     (owner_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [31:0] spi_data,
                               input int delay);
    SPI_I     = spi_data;
    eng_delay = delay;
    req_i     = req;
  endtask

  task automatic pushExp(input logic [1:0] owner, input logic err);
    exp_t e;
    e.owner = owner;
    e.err   = err;
    if (!err) model_rsp = SPI_I;
    e.rsp = model_rsp;
    sb.push_back(e);
  endtask

  task automatic waitAck(input int budget, output int cycles);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (ack_o == '0 && n < budget);
    cycles = n;
    if (ack_o == '0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ack_wait: no ack_o within %0d cycles, required an ack", budget);
    end
  endtask

  task automatic runTxn(input logic [NREQ-1:0] req, input logic [1:0] owner,
                        input logic err, input logic [31:0] spi_data, input int delay);
    int c;
    applyStimulus(req, spi_data, delay);
    pushExp(owner, err);
    waitAck(40, c);
    req_i = '0;
    @(negedge clk_i);
  endtask

  // Engine model: counts start cycles, raises done in start cycle
  // eng_delay, drops done as soon as start is seen low.
  initial begin
    forever begin
      @(negedge clk_i);
      if (SPI_START_O) begin
        start_cnt++;
        if (!eng_manual && eng_delay > 0 && start_cnt == eng_delay) SPI_DONE_I = 1'b1;
      end else begin
        if (start_cnt != 0) last_start_len = start_cnt;
        start_cnt = 0;
        if (!eng_manual) SPI_DONE_I = 1'b0;
      end
    end
  end

  // Monitor: every ack pops the oldest expected completion and compares.
  initial begin
    forever begin
      @(negedge clk_i);
      if (ack_o != '0 || err_o != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_ack: ack_o=%b err_o=%b, required no ack", ack_o, err_o);
        end else begin
          mon_exp = sb.pop_front();
          checkOutput("ack_o", 32'(ack_o), 32'(1) << mon_exp.owner);
          checkOutput("err_o", 32'(err_o), mon_exp.err ? (32'(1) << mon_exp.owner) : 32'(0));
          checkOutput("owner_o", 32'(owner_o), 32'(mon_exp.owner));
          checkOutput("rsp_dat_o", rsp_dat_o, mon_exp.rsp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_dat_i[31:0]  = 32'hA5A5_0001;
    req_sel_i[1:0]   = 2'd2;
    req_dat_i[63:32] = 32'hB0B0_0002;
    req_sel_i[3:2]   = 2'd1;

    // Reset state
    repeat (2) @(negedge clk_i);
    checkOutput("rst_start", 32'(SPI_START_O), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_spi_o", SPI_O, 32'd0);
    checkOutput("rst_sel", 32'(SPI_SEL_O), 32'd0);
    checkOutput("rst_owner", 32'(owner_o), 32'd0);
    checkOutput("rst_errcnt", 32'(err_cnt_o), 32'd0);
    checkOutput("rst_ack", 32'(ack_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Single transaction from requester 0
    applyStimulus(2'b01, 32'h1234_5678, 4);
    pushExp(2'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("t1_start", 32'(SPI_START_O), 32'd1);
    checkOutput("t1_busy", 32'(busy_o), 32'd1);
    checkOutput("t1_spi_o", SPI_O, 32'hA5A5_0001);
    checkOutput("t1_sel", 32'(SPI_SEL_O), 32'd2);
    waitAck(40, lat);
    req_i = '0;
    @(negedge clk_i);
    checkOutput("t1_idle_busy", 32'(busy_o), 32'd0);
    checkOutput("t1_spi_o_hold", SPI_O, 32'hA5A5_0001);

    // Both requesting continuously: alternate starting after last winner 0
    applyStimulus(2'b11, 32'hCAFE_0000, 2);
    pushExp(2'd1, 1'b0);
    pushExp(2'd0, 1'b0);
    pushExp(2'd1, 1'b0);
    pushExp(2'd0, 1'b0);
    waitAck(40, lat);
    checkOutput("rr_min_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) waitAck(40, lat);
    req_i = '0;
    @(negedge clk_i);
    checkOutput("rr_spi_o_hold", SPI_O, 32'hA5A5_0001);
    checkOutput("rr_sel_hold", 32'(SPI_SEL_O), 32'd2);

    // Done stuck high in IDLE blocks the grant
    eng_manual = 1'b1;
    SPI_DONE_I = 1'b1;
    applyStimulus(2'b01, 32'h0BAD_F00D, 2);
    pushExp(2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("stuck_start", 32'(SPI_START_O), 32'd0);
      checkOutput("stuck_busy", 32'(busy_o), 32'd0);
    end
    SPI_DONE_I = 1'b0;
    eng_manual = 1'b0;
    @(negedge clk_i);
    checkOutput("stuck_release_start", 32'(SPI_START_O), 32'd1);
    waitAck(40, lat);
    req_i = '0;
    @(negedge clk_i);

    // Done in the same cycle as the timeout: done wins
    runTxn(2'b01, 2'd0, 1'b0, 32'h5A5A_5A5A, TMO);
    checkOutput("same_cycle_start_len", 32'(last_start_len), 32'(TMO));
    checkOutput("same_cycle_errcnt", 32'(err_cnt_o), 32'd0);

    // Timeouts, then saturation of the error counter
    runTxn(2'b10, 2'd1, 1'b1, 32'hDEAD_0000, 0);
    checkOutput("tmo_start_len", 32'(last_start_len), 32'(TMO));
    checkOutput("tmo_errcnt_1", 32'(err_cnt_o), 32'd1);
    for (int i = 2; i <= 300; i++) begin
      runTxn(2'b10, 2'd1, 1'b1, 32'hDEAD_0000 + 32'(i), 0);
      if (i == 254) checkOutput("tmo_errcnt_254", 32'(err_cnt_o), 32'd254);
      if (i == 255) checkOutput("tmo_errcnt_255", 32'(err_cnt_o), 32'd255);
    end
    checkOutput("tmo_errcnt_sat", 32'(err_cnt_o), 32'd255);

    // Reset in the middle of ISSUE
    applyStimulus(2'b01, 32'h1111_0000, 0);
    repeat (3) @(negedge clk_i);
    checkOutput("mid_pre_start", 32'(SPI_START_O), 32'd1);
    reset_i = 1'b1;
    #1;
    checkOutput("mid_rst_start", 32'(SPI_START_O), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("mid_rst_spi_o", SPI_O, 32'd0);
    checkOutput("mid_rst_errcnt", 32'(err_cnt_o), 32'd0);
    checkOutput("mid_rst_rsp", rsp_dat_o, 32'd0);
    model_rsp = '0;
    req_i = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    runTxn(2'b11, 2'd0, 1'b0, 32'h7777_0000, 2);
    runTxn(2'b10, 2'd1, 1'b0, 32'h7777_0001, 2);
    checkOutput("post_rst_owner", 32'(owner_o), 32'd1);

    repeat (3) @(negedge clk_i);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
